// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame loader: parser states, sync marker
// default and checksum/length widths.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CSUM
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         CSUM_W            = 8;
    localparam int         REM_W             = 9;

    // A length byte of zero encodes a full 256-byte payload.
    function automatic logic [REM_W-1:0] frame_len(input logic [7:0] len);
        return (len == 8'h00) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear and
// flags when it reaches TIMEOUT_CLKS-1.
module uart_frame_timer #(
    parameter int TIMEOUT_CLKS = 2_400_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int              CNT_W = $clog2(TIMEOUT_CLKS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CLKS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates at LAST so a stalled consumer of expired_o never sees a wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_frame_loader.sv
// Serial boot loader: parses SYNC/ADDR/LEN/payload/CSUM frames from the UART
// byte stream and writes each payload byte to a byte-wide memory port.
module uart_frame_loader
    import uart_pkg::*;
#(
    parameter int         ADDR_W       = 16,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CLKS = 2_400_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              frame_ok,
    output logic              frame_bad_csum,
    output logic              frame_timeout
);

    // Handshakes: a byte moves when in_valid && in_ready; a memory write
    // completes when mem_we && mem_ready. in_ready depends on state only.
    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          wdata_q;
    logic [CSUM_W-1:0]   sum_q;
    logic [CSUM_W-1:0]   sum_d;
    logic [REM_W-1:0]    rem_q;
    logic [REM_W-1:0]    rem_d;
    logic                ok_q;
    logic                bad_q;
    logic                to_q;

    logic                accept;
    logic                tmr_clear;
    logic                tmr_expired;

    assign in_ready  = (state_q != S_WRITE);
    assign accept    = in_valid && in_ready;
    assign sum_d     = sum_q + in_data;
    assign rem_d     = rem_q - REM_W'(1);
    // Memory stalls and idle time never count toward the timeout.
    assign tmr_clear = accept || (state_q == S_IDLE) || (state_q == S_WRITE);

    uart_frame_timer #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (tmr_clear),
        .enable_i (!tmr_clear),
        .expired_o(tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            sum_q   <= '0;
            rem_q   <= '0;
            ok_q    <= 1'b0;
            bad_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            ok_q  <= 1'b0;
            bad_q <= 1'b0;
            to_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept && (in_data == SYNC_BYTE)) begin
                        state_q <= S_ADDR_HI;
                        sum_q   <= '0;
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        rem_q   <= rem_d;
                        state_q <= (rem_d == '0) ? S_CSUM : S_DATA;
                    end
                end
                default: begin
                    // An accepted byte always wins over a simultaneous expiry.
                    if (accept) begin
                        sum_q <= sum_d;
                        case (state_q)
                            S_ADDR_HI: begin
                                addr_q  <= ADDR_W'({in_data, 8'h00});
                                state_q <= S_ADDR_LO;
                            end
                            S_ADDR_LO: begin
                                addr_q[7:0] <= in_data;
                                state_q     <= S_LEN;
                            end
                            S_LEN: begin
                                rem_q   <= frame_len(in_data);
                                state_q <= S_DATA;
                            end
                            S_DATA: begin
                                wdata_q <= in_data;
                                state_q <= S_WRITE;
                            end
                            S_CSUM: begin
                                ok_q    <= (sum_d == '0);
                                bad_q   <= (sum_d != '0);
                                state_q <= S_IDLE;
                            end
                            default: state_q <= S_IDLE;
                        endcase
                    end else if (tmr_expired) begin
                        to_q    <= 1'b1;
                        state_q <= S_IDLE;
                        sum_q   <= '0;
                    end
                end
            endcase
        end
    end

    assign mem_we         = (state_q == S_WRITE);
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign busy           = (state_q != S_IDLE);
    assign frame_ok       = ok_q;
    assign frame_bad_csum = bad_q;
    assign frame_timeout  = to_q;

endmodule
